fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/cpu_pkg.sv | 34 +++
 rtl/fetch_buffer.sv | 59 +++++
 rtl/fetch_unit.sv | 125 ++++++++++++
 tb/tb_fetch_unit.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: PC source select codes, fetch FSM state type and
// the fetch buffer payload layout.
package cpu_pkg;

  localparam int unsigned PC_W   = 16;
  localparam int unsigned INST_W = 16;

  // Select codes understood by pc_block on pcSrc.
  typedef enum logic [3:0] {
    PCSRC_PC_PLUS2     = 4'd0,
    PCSRC_IMM_PLUS_PC  = 4'd1,
    PCSRC_IMM_ADDR     = 4'd2,
    PCSRC_RA           = 4'd3,
    PCSRC_MARY         = 4'd4,
    PCSRC_PC_PLUS_MARY = 4'd5,
    PCSRC_JCMP_IMM     = 4'd6,
    PCSRC_JCMP_IMM_LS  = 4'd7
  } pc_src_e;

  // IDLE: nothing outstanding; FETCH: request outstanding;
  // DROP: outstanding request became stale after a redirect.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DROP  = 2'd2
  } fetch_state_e;

  // One buffered instruction: fetch address plus instruction word.
  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry instruction FIFO between the fetch FSM and decode.
// Push and pop in the same cycle both take effect; flush empties it.
module fetch_buffer
  import cpu_pkg::*;
(
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic         flush_i,
  input  fetch_entry_t data_i,
  output fetch_entry_t data_o,
  output logic [1:0]   count_o
);

  fetch_entry_t mem_q [2];
  logic [1:0]   count_q, count_d;
  logic         rd_ptr_q, rd_ptr_d;
  logic         wr_ptr;

  // Write slot sits just behind the head; with an equal push/pop on a full
  // buffer it lands on the slot being vacated.
  assign wr_ptr  = rd_ptr_q ^ count_q[0];
  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Next occupancy and head pointer; flush wins over push/pop.
  always_comb begin
    // NOTE: defaults come first so every path assigns and no latch is inferred.
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    if (flush_i) begin
      count_d  = '0;
      rd_ptr_d = 1'b0;
    end else begin
      count_d = count_q + {1'b0, push_i} - {1'b0, pop_i};
      if (pop_i) rd_ptr_d = ~rd_ptr_q;
    end
  end

  // Storage and pointer registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      // NOTE: the two payload slots are reset too so the head reads 0 after
      // reset; larger memories would normally be left unreset.
      count_q  <= '0;
      rd_ptr_q <= 1'b0;
      mem_q[0] <= '0;
      mem_q[1] <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling the
      // pre-edge values regardless of statement order.
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      if (push_i && !flush_i) mem_q[wr_ptr] <= data_i;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues single outstanding reads to instruction
// memory, buffers up to two instructions for decode, and steers pc_block.
// Optional feature: define FETCH_STALL_CNT_EN to add the stallCnt output.
module fetch_unit
  import cpu_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] pcCur,
  output logic        pcWrite,
  output logic [3:0]  pcSrc,
  input  logic        redirValid,
  input  logic [3:0]  redirSrc,
  output logic        memReq,
  output logic [15:0] memAddr,
  input  logic        memReady,
  input  logic [15:0] memData,
  output logic        instValid,
  output logic [15:0] instData,
  output logic [15:0] instPC,
  input  logic        instReady
`ifdef FETCH_STALL_CNT_EN
  ,
  output logic [15:0] stallCnt
`endif
);

  fetch_state_e state_q, state_d;
  logic [15:0]  mem_addr_q, mem_addr_d;
  logic [1:0]   fifo_count;
  logic [1:0]   count_after_pop;
  logic         pop, launch, active, push;
  fetch_entry_t push_entry, head;

  assign instValid = (fifo_count != 2'd0);
  assign instPC    = head.pc;
  assign instData  = head.inst;

  // Launch needs room after this cycle's pop; a redirect cycle never launches
  // because pcCur is about to be replaced.
  always_comb begin
    pop             = instValid && instReady;
    count_after_pop = fifo_count - {1'b0, pop};
    launch          = (state_q == ST_IDLE) && !reset && !redirValid &&
                      (count_after_pop <= 2'd1);
    active          = launch || (state_q == ST_FETCH);
    push            = active && memReady && !redirValid && !reset;
  end

  // Next-state, memory request and PC steering.
  always_comb begin
    state_d    = state_q;
    mem_addr_d = mem_addr_q;
    memReq     = 1'b0;
    memAddr    = mem_addr_q;
    pcWrite    = 1'b0;
    pcSrc      = PCSRC_PC_PLUS2;
    case (state_q)
      ST_IDLE: begin
        if (launch) begin
          memReq     = 1'b1;
          memAddr    = pcCur;
          mem_addr_d = pcCur;
          if (!memReady) state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        memReq = 1'b1;
        if (memReady)        state_d = ST_IDLE;
        else if (redirValid) state_d = ST_DROP;
      end
      ST_DROP: begin
        memReq = 1'b1;
        if (memReady) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (push) pcWrite = 1'b1;
    if (redirValid && !reset) begin
      pcWrite = 1'b1;
      pcSrc   = redirSrc;
    end
  end

  // FSM state and captured request address.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      mem_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      mem_addr_q <= mem_addr_d;
    end
  end

  assign push_entry = '{pc: memAddr, inst: memData};

  fetch_buffer u_buf (
    .clk_i   (clock),
    .rst_i   (reset),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (redirValid),
    .data_i  (push_entry),
    .data_o  (head),
    .count_o (fifo_count)
  );

`ifdef FETCH_STALL_CNT_EN
  logic [15:0] stall_cnt_q;
  logic        stall;

  assign stall    = (instValid && !instReady) || (memReq && !memReady);
  assign stallCnt = stall_cnt_q;

  // Saturating count of decode back-pressure and memory wait cycles.
  always_ff @(posedge clock) begin
    if (reset)                                  stall_cnt_q <= '0;
    else if (stall && stall_cnt_q != 16'hFFFF)  stall_cnt_q <= stall_cnt_q + 16'd1;
  end
`else
  // Stall counter not built in this configuration.
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed vector tables, hand-written
// redirect/reset sequences and a randomized run against a queue-based model.
module tb_fetch_unit;
  import cpu_pkg::*;

  localparam logic [15:0] DKEY = 16'h5A3C;

  logic        clock;
  logic        reset;
  logic [15:0] pcCur;
  logic        pcWrite;
  logic [3:0]  pcSrc;
  logic        redirValid;
  logic [3:0]  redirSrc;
  logic        memReq;
  logic [15:0] memAddr;
  logic        memReady;
  logic [15:0] memData;
  logic        instValid;
  logic [15:0] instData;
  logic [15:0] instPC;
  logic        instReady;
`ifdef FETCH_STALL_CNT_EN
  logic [15:0] stallCnt;
`endif

  int n_checks = 0;
  int n_fails  = 0;

  fetch_unit dut (
`ifdef FETCH_STALL_CNT_EN
    .stallCnt   (stallCnt),
`endif
    .clock      (clock),
    .reset      (reset),
    .pcCur      (pcCur),
    .pcWrite    (pcWrite),
    .pcSrc      (pcSrc),
    .redirValid (redirValid),
    .redirSrc   (redirSrc),
    .memReq     (memReq),
    .memAddr    (memAddr),
    .memReady   (memReady),
    .memData    (memData),
    .instValid  (instValid),
    .instData   (instData),
    .instPC     (instPC),
    .instReady  (instReady)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Instruction memory: word content is a fixed function of its address.
  assign memData = memAddr ^ DKEY;

  typedef struct packed {
    logic [15:0] pc;
    logic        mr, ir, rv;
    logic [3:0]  rs;
    logic        req;
    logic [15:0] addr;
    logic        pcw;
    logic [3:0]  src;
    logic        iv;
    logic [15:0] ipc;
  } vec_t;

  function automatic vec_t v(logic [15:0] pc, logic mr, logic ir, logic rv,
                             logic [3:0] rs, logic req, logic [15:0] addr,
                             logic pcw, logic [3:0] src, logic iv,
                             logic [15:0] ipc);
    vec_t r;
    r = '{pc: pc, mr: mr, ir: ir, rv: rv, rs: rs, req: req, addr: addr,
          pcw: pcw, src: src, iv: iv, ipc: ipc};
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [15:0] pc, input logic mr, input logic ir,
                       input logic rv, input logic [3:0] rs);
    pcCur      = pc;
    memReady   = mr;
    instReady  = ir;
    redirValid = rv;
    redirSrc   = rs;
  endtask

  // Apply one cycle of inputs, compare at the falling edge, advance.
  task automatic run_vec(input string tag, input vec_t t);
    drive(t.pc, t.mr, t.ir, t.rv, t.rs);
    @(negedge clock);
    check({tag, "_memReq"},    32'(memReq),    32'(t.req));
    check({tag, "_memAddr"},   32'(memAddr),   32'(t.addr));
    check({tag, "_pcWrite"},   32'(pcWrite),   32'(t.pcw));
    check({tag, "_pcSrc"},     32'(pcSrc),     32'(t.src));
    check({tag, "_instValid"}, 32'(instValid), 32'(t.iv));
    if (t.iv) begin
      check({tag, "_instPC"},   32'(instPC),   32'(t.ipc));
      check({tag, "_instData"}, 32'(instData), 32'(t.ipc ^ DKEY));
    end
    @(posedge clock); #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    drive(16'h0000, 1'b0, 1'b0, 1'b0, 4'd0);
    @(posedge clock); #1;
    @(posedge clock); #1;
    reset = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_memReq"},    32'(memReq),    32'd0);
    check({tag, "_memAddr"},   32'(memAddr),   32'd0);
    check({tag, "_pcWrite"},   32'(pcWrite),   32'd0);
    check({tag, "_pcSrc"},     32'(pcSrc),     32'd0);
    check({tag, "_instValid"}, 32'(instValid), 32'd0);
    check({tag, "_instData"},  32'(instData),  32'd0);
    check({tag, "_instPC"},    32'(instPC),    32'd0);
  endtask

  vec_t vecs[$];

  // Model state for the randomized run.
  fetch_entry_t mq[$];
  bit           pend, stale;
  logic [15:0]  last_addr, pc_m;
  int           stall_m;

  initial begin
    // Directed table: sequential fetch, back-pressure, redirects.
    vecs.push_back(v(16'h0000,1,1,0,0, 1,16'h0000,1,0, 0,16'h0000));
    vecs.push_back(v(16'h0002,1,1,0,0, 1,16'h0002,1,0, 1,16'h0000));
    vecs.push_back(v(16'h0004,1,1,0,0, 1,16'h0004,1,0, 1,16'h0002));
    vecs.push_back(v(16'h0006,1,1,0,0, 1,16'h0006,1,0, 1,16'h0004));
    vecs.push_back(v(16'h0008,1,0,0,0, 1,16'h0008,1,0, 1,16'h0006));
    vecs.push_back(v(16'h000A,1,0,0,0, 0,16'h0008,0,0, 1,16'h0006));
    vecs.push_back(v(16'h000A,1,0,0,0, 0,16'h0008,0,0, 1,16'h0006));
    vecs.push_back(v(16'h000A,1,1,0,0, 1,16'h000A,1,0, 1,16'h0006));
    vecs.push_back(v(16'h000C,0,1,0,0, 1,16'h000C,0,0, 1,16'h0008));
    vecs.push_back(v(16'h000C,0,1,0,0, 1,16'h000C,0,0, 1,16'h000A));
    vecs.push_back(v(16'h000C,0,1,1,2, 1,16'h000C,1,2, 0,16'h0000));
    vecs.push_back(v(16'h0040,0,1,0,0, 1,16'h000C,0,0, 0,16'h0000));
    vecs.push_back(v(16'h0040,1,1,0,0, 1,16'h000C,0,0, 0,16'h0000));
    vecs.push_back(v(16'h0040,1,1,0,0, 1,16'h0040,1,0, 0,16'h0000));
    vecs.push_back(v(16'h0042,1,1,1,5, 0,16'h0040,1,5, 1,16'h0040));
    vecs.push_back(v(16'h0080,1,1,0,0, 1,16'h0080,1,0, 0,16'h0000));
    vecs.push_back(v(16'h0082,0,1,0,0, 1,16'h0082,0,0, 1,16'h0080));
    vecs.push_back(v(16'h0082,1,1,1,3, 1,16'h0082,1,3, 0,16'h0000));
    vecs.push_back(v(16'h0100,0,1,0,0, 1,16'h0100,0,0, 0,16'h0000));
    vecs.push_back(v(16'h0100,1,1,0,0, 1,16'h0100,1,0, 0,16'h0000));
    vecs.push_back(v(16'h0102,0,1,0,0, 1,16'h0102,0,0, 1,16'h0100));

    // Reset state, with a nonzero pcCur to show nothing leaks through.
    reset = 1'b1;
    drive(16'h1234, 1'b1, 1'b1, 1'b0, 4'd0);
    @(posedge clock); #1;
    @(negedge clock);
    check_all_zero("rst");
    @(posedge clock); #1;
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) run_vec("tbl", vecs[i]);

    // Redirect while a request to 0x0010 waits three cycles.
    apply_reset();
    run_vec("drop", v(16'h0010,0,1,0,0, 1,16'h0010,0,0, 0,16'h0000));
    run_vec("drop", v(16'h0010,0,1,1,2, 1,16'h0010,1,2, 0,16'h0000));
    run_vec("drop", v(16'h0200,0,1,0,0, 1,16'h0010,0,0, 0,16'h0000));
    run_vec("drop", v(16'h0200,1,1,0,0, 1,16'h0010,0,0, 0,16'h0000));
    run_vec("drop", v(16'h0200,1,1,0,0, 1,16'h0200,1,0, 0,16'h0000));
    run_vec("drop", v(16'h0202,0,1,0,0, 1,16'h0202,0,0, 1,16'h0200));

    // Reset while holding an entry and a pending request.
    apply_reset();
    run_vec("mrst", v(16'h0030,1,0,0,0, 1,16'h0030,1,0, 0,16'h0000));
    run_vec("mrst", v(16'h0032,0,0,0,0, 1,16'h0032,0,0, 1,16'h0030));
    reset = 1'b1;
    drive(16'h1234, 1'b0, 1'b0, 1'b1, 4'd6);
    @(posedge clock); #1;
    @(negedge clock);
    check_all_zero("mrst");
    @(posedge clock); #1;
    reset = 1'b0;

`ifdef FETCH_STALL_CNT_EN
    // Five cycles of decode back-pressure with 0-wait memory.
    apply_reset();
    drive(16'h0000, 1'b1, 1'b1, 1'b0, 4'd0);
    @(posedge clock); #1;
    drive(16'h0002, 1'b1, 1'b0, 1'b0, 4'd0);
    @(posedge clock); #1;
    for (int i = 0; i < 4; i++) begin
      drive(16'h0004, 1'b1, 1'b0, 1'b0, 4'd0);
      @(posedge clock); #1;
    end
    drive(16'h0004, 1'b0, 1'b1, 1'b0, 4'd0);
    @(negedge clock);
    check("stall_cnt5", 32'(stallCnt), 32'd5);
    @(posedge clock); #1;
`endif

    // Randomized run against the queue model.
    apply_reset();
    mq.delete();
    pend      = 1'b0;
    stale     = 1'b0;
    last_addr = 16'h0000;
    pc_m      = 16'h0100;
    stall_m   = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic       mr, ir, rv, pop_m, can, e_req, arrive, good, e_pcw;
      logic [3:0] rs, e_src;
      logic [15:0] e_addr;
      int         occ;
      mr = ($urandom_range(0, 99) < 55);
      ir = ($urandom_range(0, 99) < 65);
      rv = ($urandom_range(0, 99) < 7);
      rs = 4'($urandom_range(1, 7));
      drive(pc_m, mr, ir, rv, rs);
      pop_m  = (mq.size() > 0) && ir;
      occ    = mq.size() - (pop_m ? 1 : 0);
      can    = !pend && !rv && (occ <= 1);
      e_req  = pend || can;
      e_addr = can ? pc_m : last_addr;
      arrive = e_req && mr;
      good   = arrive && !stale && !rv;
      e_pcw  = rv || good;
      e_src  = rv ? rs : 4'd0;
      @(negedge clock);
      check("rnd_memReq",    32'(memReq),    32'(e_req));
      check("rnd_memAddr",   32'(memAddr),   32'(e_addr));
      check("rnd_pcWrite",   32'(pcWrite),   32'(e_pcw));
      check("rnd_pcSrc",     32'(pcSrc),     32'(e_src));
      check("rnd_instValid", 32'(instValid), 32'(mq.size() > 0));
      if (mq.size() > 0) begin
        check("rnd_instPC",   32'(instPC),   32'(mq[0].pc));
        check("rnd_instData", 32'(instData), 32'(mq[0].inst));
      end
`ifdef FETCH_STALL_CNT_EN
      check("rnd_stallCnt", 32'(stallCnt), 32'(stall_m));
      if (((mq.size() > 0) && !ir) || (e_req && !mr))
        if (stall_m < 65535) stall_m++;
`endif
      if (can) last_addr = pc_m;
      if (rv) mq.delete();
      else begin
        if (pop_m) void'(mq.pop_front());
        if (good) mq.push_back('{pc: e_addr, inst: e_addr ^ DKEY});
      end
      if (arrive) begin
        pend  = 1'b0;
        stale = 1'b0;
      end else if (e_req) begin
        pend = 1'b1;
        if (rv) stale = 1'b1;
      end
      if (rv)        pc_m = 16'($urandom_range(0, 32767)) << 1;
      else if (good) pc_m = pc_m + 16'd2;
      @(posedge clock); #1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
